add_seq16: RTL and testbench

ADD_SEQ16 -- requirements
Module: add_seq16

---
 rtl/add_seq16_pkg.sv | 13 +
 rtl/add_seq16_adder.sv | 25 ++
 rtl/add_seq16.sv | 110 +++++++++++
 tb/tb_add_seq16.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/add_seq16_pkg.sv
// Shared constants and FSM encoding for the chunk-serial adder/subtractor.
package add_seq16_pkg;

  localparam int CHUNK = 16;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_seq16_adder.sv
// 16-bit ripple-carry adder built from a chain of full-adder cells.
module adder
  import add_seq16_pkg::*;
(
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
      assign sum[gi]       = x[gi] ^ y[gi] ^ carry[gi];
      assign carry[gi + 1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
    end
  endgenerate

  assign cout = carry[CHUNK];

endmodule

// File: rtl/add_seq16.sv
// Multi-word add/subtract that time-shares one 16-bit adder, least-significant
// chunk first, with valid/ready handshakes on both sides.
module add_seq16
  import add_seq16_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHUNK*WORDS-1:0] a,
  input  logic [CHUNK*WORDS-1:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHUNK*WORDS-1:0] result,
  output logic                 cout,
  output logic                 overflow
);

  localparam int W = CHUNK * WORDS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  generate
    if (WORDS < 2 || WORDS > 8) begin : g_bad_words
      $error("add_seq16: WORDS must be in 2..8");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [W-1:0]     a_reg, b_reg, result_reg;
  logic             carry_reg, cout_reg, overflow_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [CHUNK-1:0] a_chunk, b_chunk, sum;
  logic             add_cout;
  logic             accept, last;

  assign accept  = in_valid && in_ready;
  assign last    = (cnt_reg == LAST);
  assign a_chunk = a_reg[int'(cnt_reg)*CHUNK +: CHUNK];
  assign b_chunk = b_reg[int'(cnt_reg)*CHUNK +: CHUNK];

  adder u_adder (
    .x    (a_chunk),
    .y    (b_chunk),
    .cin  (carry_reg),
    .sum  (sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Leaving DONE always lands in IDLE, so a new operand waits at least one cycle.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      carry_reg    <= 1'b0;
      cnt_reg      <= '0;
      result_reg   <= '0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: invert b once here and seed the carry.
      a_reg     <= a;
      b_reg     <= sub ? ~b : b;
      carry_reg <= sub;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      result_reg[int'(cnt_reg)*CHUNK +: CHUNK] <= sum;
      carry_reg <= add_cout;
      if (last) begin
        cout_reg     <= add_cout;
        overflow_reg <= (a_reg[W-1] == b_reg[W-1]) && (sum[CHUNK-1] != a_reg[W-1]);
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign result   = result_reg;
  assign cout     = cout_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_add_seq16.sv
// Self-checking bench for add_seq16 (WORDS=4): directed table, randomized ops
// against an arithmetic model, and hand-written stall / mid-run reset sequences.
module tb_add_seq16;

  localparam int WORDS = 4;
  localparam int W     = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_seq16 #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the full operand width.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                                output logic [W-1:0] r, output logic c, output logic o);
    logic [W:0]          u;
    logic signed [W+1:0] sa, sb, sv;
    sa = $signed({{2{ma[W-1]}}, ma});
    sb = $signed({{2{mb[W-1]}}, mb});
    if (ms) begin
      r  = ma - mb;
      c  = (ma >= mb);
      sv = sa - sb;
    end else begin
      u  = {1'b0, ma} + {1'b0, mb};
      r  = u[W-1:0];
      c  = u[W];
      sv = sa + sb;
    end
    o = (sv > $signed(66'sh0_7FFF_FFFF_FFFF_FFFF)) || (sv < -$signed(66'sh0_8000_0000_0000_0000));
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return '1;
      1:       return {1'b1, {(W-1){1'b0}}};
      2:       return W'($urandom_range(0, 3));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One full transaction: present, time the result, compare, optionally retire.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts,
                       input logic [W-1:0] er, input logic ec, input logic eo,
                       input string tag, input bit retire);
    int n;
    @(negedge clk);
    check({tag, ".in_ready"}, W'(in_ready), W'(1'b1));
    a = ta; b = tbv; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    // WORDS further edges after the accepting one (WORDS+1 counting it).
    check({tag, ".latency"}, W'(n), W'(WORDS));
    check({tag, ".result"}, result, er);
    check({tag, ".cout"}, W'(cout), W'(ec));
    check({tag, ".overflow"}, W'(overflow), W'(eo));
    $display("op %s a=%h b=%h sub=%0d -> result=%h cout=%0d ovf=%0d edges=%0d",
             tag, ta, tbv, ts, result, cout, overflow, n + 1);
    if (retire) begin
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, ".retire"}, W'({out_valid, in_ready}), W'(2'b01));
      out_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb, er;
    logic         rs, ec, eo;
    bit           saw_valid;

    vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[3] = '{64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};

    // Reset values while rst_n is held low.
    #1;
    check("rst.in_ready", W'(in_ready), W'(1'b1));
    check("rst.out_valid", W'(out_valid), W'(1'b0));
    check("rst.result", result, '0);
    check("rst.flags", W'({cout, overflow}), W'(2'b00));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].r, vecs[i].c, vecs[i].o,
            $sformatf("vec%0d", i), 1'b1);

    for (int i = 0; i < 24; i++) begin
      ra = pick(); rb = pick(); rs = 1'($urandom);
      model(ra, rb, rs, er, ec, eo);
      do_op(ra, rb, rs, er, ec, eo, $sformatf("rnd%0d", i), 1'b1);
    end

    // Consumer stall: outputs hold, new operands ignored, no bypass on release.
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b0, 64'h1, 1'b1, 1'b0, "stall", 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom};
      check($sformatf("stall%0d.hs", i), W'({out_valid, in_ready}), W'(2'b10));
      check($sformatf("stall%0d.out", i), {result[W-1:2], cout, overflow}, {62'h0, 1'b1, 1'b0});
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall.release", W'({out_valid, in_ready}), W'(2'b01));
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("stall.nobypass", W'(in_ready), W'(1'b1));
    check("idle.retain", result, 64'h1);

    // Reset pulse while chunk 2 is in flight.
    @(negedge clk);
    a = 64'h1111_1111_1111_1111; b = 64'h2222_2222_2222_2222; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst.hs", W'({out_valid, in_ready}), W'(2'b01));
    check("midrst.result", result, '0);
    check("midrst.flags", W'({cout, overflow}), W'(2'b00));
    @(negedge clk); rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst.abandon", W'(saw_valid), W'(1'b0));
    do_op(64'h1234, 64'h1, 1'b0, 64'h1235, 1'b0, 1'b0, "postrst", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
